legv8_decode_ctrl: RTL and testbench
====================================

Name: legv8_decode_ctrl

Overview:
- Registered instruction decoder for the LEGv8 single-cycle/pipelined datapath.
- Fuses the main control unit and the ALU control unit into one block.
- Takes a 32-bit instruction and produces datapath control strobes, the 2-bit ALU_OP class and the 4-bit ALU operation select.
- Outputs are registered: results appear one clock after the instruction is presented.

Parameters:
- None. Opcode encodings are fixed by the LEGv8 ISA subset below.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction input qualifier
- instruction  in  32  instruction word
- out_valid  out  1  registered instr_valid
- reg2loc  out  1  register-read-2 select (1 = Rt field [4:0], 0 = Rm field [20:16])
- alu_src  out  1  ALU B operand (1 = immediate/offset, 0 = register)
- mem2reg  out  1  writeback source (1 = memory, 0 = ALU)
- reg_write  out  1  register file write enable
- mem_read  out  1  data memory read enable
- mem_write  out  1  data memory write enable
- branch  out  1  conditional branch
- alu_op  out  2  ALU class (00 = add/address, 01 = pass-B/compare, 10 = R-type function)
- alu_signal  out  4  ALU operation select
- illegal  out  1  valid instruction matched no supported opcode

Behaviour:
- Reset: while rst_n = 0 (asserted asynchronously), every output is 0. This includes out_valid, illegal, alu_op = 00 and alu_signal = 0000. The clear takes effect immediately, including in the middle of a stream.
- Latency: combinational decode, then one register stage.
  - Outputs at edge N+1 reflect the instruction sampled at edge N.
  - out_valid follows instr_valid with the same latency.
- instr_valid = 0 at an edge: the next cycle has all strobes 0, alu_op = 00, alu_signal = 0000, illegal = 0 and out_valid = 0. Idle cycles never produce spurious writes.
- Opcode match: exact equality on instruction[31:21] for 11-bit opcodes; instruction[31:24] for CBZ. The encodings are mutually exclusive, so no priority is needed.
- Strobe values, listed as R2L AS M2R RW MR MW B, then ALU_OP:
  - ADD 10001011000 (1112): 0 0 0 1 0 0 0, alu_op 10.
  - SUB 11001011000 (1624): 0 0 0 1 0 0 0, alu_op 10.
  - AND 10001010000 (1104): 0 0 0 1 0 0 0, alu_op 10.
  - ORR 10101010000 (1360): 0 0 0 1 0 0 0, alu_op 10.
  - LDUR 11111000010 (1986): 0 1 1 1 1 0 0, alu_op 00.
  - STUR 11111000000 (1984): 1 1 0 0 0 1 0, alu_op 00. mem2reg is driven 0 (not a don't-care).
  - CBZ 10110100 (180): 1 0 0 0 0 0 1, alu_op 01.
  - Anything else (including all-zero): all strobes 0, alu_op 00, illegal = 1.
- ALU control. Define f = {instruction[30], instruction[29], instruction[24]}.
  - alu_op 00 -> alu_signal 0010 (add).
  - alu_op 01 -> alu_signal 0111 (pass B).
  - alu_op 10, by f:
    - f = 001 -> 0010 (ADD)
    - f = 101 -> 0110 (SUB)
    - f = 000 -> 0000 (AND)
    - f = 010 -> 0001 (ORR)
    - any other f -> 0010
  - alu_op 11 (unreachable) -> 0010.
- Illegal case: alu_signal = 0010, consistent with alu_op = 00.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with LDUR pending -> all outputs 0 immediately. After release with instr_valid = 0 -> outputs stay 0.
- R-type: drive ADD, SUB, AND, ORR back-to-back with instr_valid = 1, one per cycle.
  - Each -> one cycle later: R2L0 AS0 M2R0 RW1 MR0 MW0 B0, alu_op 10.
  - alu_signal 0010 / 0110 / 0000 / 0001 respectively.
  - out_valid = 1 throughout.
- LDUR: instruction[31:21] = 1986, other bits 0 -> R2L0 AS1 M2R1 RW1 MR1 MW0 B0, alu_op 00, alu_signal 0010.
- STUR and CBZ:
  - STUR, instruction[31:21] = 1984 -> R2L1 AS1 M2R0 RW0 MR0 MW1 B0, alu_signal 0010.
  - CBZ, instruction[31:24] = 180 -> R2L1 AS0 M2R0 RW0 MR0 MW0 B1, alu_op 01, alu_signal 0111.
- Illegal/idle:
  - instruction = 0 with instr_valid = 1 -> all strobes 0, illegal = 1, out_valid = 1.
  - Same instruction with instr_valid = 0 -> illegal = 0, out_valid = 0.

Source files
------------

// File: rtl/legv8_decode_ctrl.sv
// Registered LEGv8 decoder: main control and ALU control fused, one register stage.
// Control strobes, ALU class and ALU operation select appear one clock after the instruction.
module legv8_decode_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [31:0] instruction_i,
  output logic        out_valid_o,
  output logic        reg2loc_o,
  output logic        alu_src_o,
  output logic        mem2reg_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        branch_o,
  output logic [1:0]  alu_op_o,
  output logic [3:0]  alu_signal_o,
  output logic        illegal_o
);

  localparam logic [10:0] OP_ADD  = 11'd1112;
  localparam logic [10:0] OP_SUB  = 11'd1624;
  localparam logic [10:0] OP_AND  = 11'd1104;
  localparam logic [10:0] OP_ORR  = 11'd1360;
  localparam logic [10:0] OP_LDUR = 11'd1986;
  localparam logic [10:0] OP_STUR = 11'd1984;
  localparam logic [7:0]  OP_CBZ  = 8'd180;

  localparam logic [1:0] ALUOP_ADDR = 2'b00;
  localparam logic [1:0] ALUOP_PASS = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  logic [10:0] opcode;
  logic [2:0]  func;

  logic       out_valid_d, out_valid_q;
  logic       reg2loc_d, reg2loc_q;
  logic       alu_src_d, alu_src_q;
  logic       mem2reg_d, mem2reg_q;
  logic       reg_write_d, reg_write_q;
  logic       mem_read_d, mem_read_q;
  logic       mem_write_d, mem_write_q;
  logic       branch_d, branch_q;
  logic [1:0] alu_op_d, alu_op_q;
  logic [3:0] alu_signal_d, alu_signal_q;
  logic       illegal_d, illegal_q;

  // Register/immediate operand fields do not influence control.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instruction_i[20:0];

  assign opcode = instruction_i[31:21];
  assign func   = {instruction_i[30], instruction_i[29], instruction_i[24]};

  // Main control; an idle cycle leaves everything at zero.
  always_comb begin
    out_valid_d = 1'b0;
    reg2loc_d   = 1'b0;
    alu_src_d   = 1'b0;
    mem2reg_d   = 1'b0;
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 1'b0;
    alu_op_d    = ALUOP_ADDR;
    illegal_d   = 1'b0;
    if (instr_valid_i) begin
      out_valid_d = 1'b1;
      if (instruction_i[31:24] == OP_CBZ) begin
        reg2loc_d = 1'b1;
        branch_d  = 1'b1;
        alu_op_d  = ALUOP_PASS;
      end else begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            reg_write_d = 1'b1;
            alu_op_d    = ALUOP_FUNC;
          end
          OP_LDUR: begin
            alu_src_d   = 1'b1;
            mem2reg_d   = 1'b1;
            reg_write_d = 1'b1;
            mem_read_d  = 1'b1;
          end
          OP_STUR: begin
            reg2loc_d   = 1'b1;
            alu_src_d   = 1'b1;
            mem_write_d = 1'b1;
          end
          default: illegal_d = 1'b1;
        endcase
      end
    end
  end

  // ALU control; gated by valid so idle cycles report 0000.
  always_comb begin
    alu_signal_d = 4'b0000;
    if (instr_valid_i) begin
      case (alu_op_d)
        ALUOP_ADDR: alu_signal_d = ALU_ADD;
        ALUOP_PASS: alu_signal_d = ALU_PASS;
        ALUOP_FUNC: begin
          case (func)
            3'b001:  alu_signal_d = ALU_ADD;
            3'b101:  alu_signal_d = ALU_SUB;
            3'b000:  alu_signal_d = ALU_AND;
            3'b010:  alu_signal_d = ALU_ORR;
            default: alu_signal_d = ALU_ADD;
          endcase
        end
        default: alu_signal_d = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      reg2loc_q    <= 1'b0;
      alu_src_q    <= 1'b0;
      mem2reg_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= 1'b0;
      alu_op_q     <= 2'b00;
      alu_signal_q <= 4'b0000;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      reg2loc_q    <= reg2loc_d;
      alu_src_q    <= alu_src_d;
      mem2reg_q    <= mem2reg_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      branch_q     <= branch_d;
      alu_op_q     <= alu_op_d;
      alu_signal_q <= alu_signal_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign reg2loc_o    = reg2loc_q;
  assign alu_src_o    = alu_src_q;
  assign mem2reg_o    = mem2reg_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign branch_o     = branch_q;
  assign alu_op_o     = alu_op_q;
  assign alu_signal_o = alu_signal_q;
  assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_legv8_decode_ctrl.sv
// Bench for legv8_decode_ctrl: directed vector table, reset/idle sequences, random vs. mnemonic model.
// Output vector packing: {out_valid, r2l, as, m2r, rw, mr, mw, b, alu_op[1:0], alu_signal[3:0], illegal}.
module tb_legv8_decode_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        instr_valid_i;
  logic [31:0] instruction_i;
  logic        out_valid_o, reg2loc_o, alu_src_o, mem2reg_o, reg_write_o;
  logic        mem_read_o, mem_write_o, branch_o, illegal_o;
  logic [1:0]  alu_op_o;
  logic [3:0]  alu_signal_o;

  int total = 0;
  int bad   = 0;

  legv8_decode_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .instr_valid_i(instr_valid_i),
    .instruction_i(instruction_i),
    .out_valid_o  (out_valid_o),
    .reg2loc_o    (reg2loc_o),
    .alu_src_o    (alu_src_o),
    .mem2reg_o    (mem2reg_o),
    .reg_write_o  (reg_write_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .branch_o     (branch_o),
    .alu_op_o     (alu_op_o),
    .alu_signal_o (alu_signal_o),
    .illegal_o    (illegal_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [14:0] obs;
  assign obs = {out_valid_o, reg2loc_o, alu_src_o, mem2reg_o, reg_write_o, mem_read_o,
                mem_write_o, branch_o, alu_op_o, alu_signal_o, illegal_o};

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] instr;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: name the instruction, then look up its row in the ISA control table.
  function automatic logic [14:0] ref_model(input logic v, input logic [31:0] ins);
    int op11;
    int op8;
    string mn;
    op11 = int'(ins[31:21]);
    op8  = int'(ins[31:24]);
    if (!v) return 15'd0;
    if      (op11 == 1112) mn = "ADD";
    else if (op11 == 1624) mn = "SUB";
    else if (op11 == 1104) mn = "AND";
    else if (op11 == 1360) mn = "ORR";
    else if (op11 == 1986) mn = "LDUR";
    else if (op11 == 1984) mn = "STUR";
    else if (op8  == 180)  mn = "CBZ";
    else                   mn = "ILL";
    case (mn)
      "ADD":   return {1'b1, 7'b0001000, 2'b10, 4'd2, 1'b0};
      "SUB":   return {1'b1, 7'b0001000, 2'b10, 4'd6, 1'b0};
      "AND":   return {1'b1, 7'b0001000, 2'b10, 4'd0, 1'b0};
      "ORR":   return {1'b1, 7'b0001000, 2'b10, 4'd1, 1'b0};
      "LDUR":  return {1'b1, 7'b0111100, 2'b00, 4'd2, 1'b0};
      "STUR":  return {1'b1, 7'b1100010, 2'b00, 4'd2, 1'b0};
      "CBZ":   return {1'b1, 7'b1000001, 2'b01, 4'd7, 1'b0};
      default: return {1'b1, 7'b0000000, 2'b00, 4'd2, 1'b1};
    endcase
  endfunction

  task automatic check(input string name, input logic [14:0] got, input logic [14:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b", name, got, exp);
    end
  endtask

  // Drive at the falling edge, sample 1ns after the following rising edge.
  task automatic step(input logic v, input logic [31:0] ins);
    @(negedge clk_i);
    instr_valid_i = v;
    instruction_i = ins;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int sel;
    r   = $urandom;
    sel = $urandom_range(0, 8);
    case (sel)
      0: r[31:21] = 11'd1112;
      1: r[31:21] = 11'd1624;
      2: r[31:21] = 11'd1104;
      3: r[31:21] = 11'd1360;
      4: r[31:21] = 11'd1986;
      5: r[31:21] = 11'd1984;
      6: r[31:24] = 8'd180;
      7: r = 32'd0;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] ri;
    logic        rv;

    vecs.push_back('{"add", 1'b1, {11'd1112, 5'd3, 6'd0, 5'd2, 5'd1},  {1'b1, 7'b0001000, 2'b10, 4'b0010, 1'b0}});
    vecs.push_back('{"sub", 1'b1, {11'd1624, 5'd4, 6'd0, 5'd5, 5'd6},  {1'b1, 7'b0001000, 2'b10, 4'b0110, 1'b0}});
    vecs.push_back('{"and", 1'b1, {11'd1104, 5'd7, 6'd0, 5'd8, 5'd9},  {1'b1, 7'b0001000, 2'b10, 4'b0000, 1'b0}});
    vecs.push_back('{"orr", 1'b1, {11'd1360, 5'd10, 6'd0, 5'd11, 5'd12}, {1'b1, 7'b0001000, 2'b10, 4'b0001, 1'b0}});
    vecs.push_back('{"ldur", 1'b1, {11'd1986, 21'd0},        {1'b1, 7'b0111100, 2'b00, 4'b0010, 1'b0}});
    vecs.push_back('{"stur", 1'b1, {11'd1984, 21'd0},        {1'b1, 7'b1100010, 2'b00, 4'b0010, 1'b0}});
    vecs.push_back('{"cbz", 1'b1, {8'd180, 24'h00_0123},     {1'b1, 7'b1000001, 2'b01, 4'b0111, 1'b0}});
    vecs.push_back('{"illegal_zero", 1'b1, 32'd0,            {1'b1, 7'b0000000, 2'b00, 4'b0010, 1'b1}});
    vecs.push_back('{"idle_zero", 1'b0, 32'd0,               15'd0});
    vecs.push_back('{"idle_ldur", 1'b0, {11'd1986, 21'd0},   15'd0});
    vecs.push_back('{"stur_fields", 1'b1, {11'd1984, 9'h1FF, 2'b00, 5'd31, 5'd30}, {1'b1, 7'b1100010, 2'b00, 4'b0010, 1'b0}});
    vecs.push_back('{"near_add", 1'b1, {11'd1113, 21'd0},    {1'b1, 7'b0000000, 2'b00, 4'b0010, 1'b1}});

    rst_ni        = 1'b0;
    instr_valid_i = 1'b0;
    instruction_i = 32'd0;
    #3;
    check("reset_init", obs, 15'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Directed table, back-to-back one per cycle.
    foreach (vecs[i]) begin
      step(vecs[i].valid, vecs[i].instr);
      check(vecs[i].name, obs, vecs[i].exp);
    end

    // Asynchronous reset mid-stream with LDUR held at the input.
    step(1'b1, {11'd1986, 21'd0});
    check("ldur_before_reset", obs, {1'b1, 7'b0111100, 2'b00, 4'b0010, 1'b0});
    #2;
    rst_ni = 1'b0;
    #1;
    check("reset_async_clear", obs, 15'd0);
    @(posedge clk_i);
    #1;
    check("reset_held_edge", obs, 15'd0);
    @(negedge clk_i);
    instr_valid_i = 1'b0;
    rst_ni        = 1'b1;
    @(posedge clk_i);
    #1;
    check("after_release_idle", obs, 15'd0);

    // Same illegal word valid, then invalid.
    step(1'b1, 32'd0);
    check("illegal_valid", obs, {1'b1, 7'b0000000, 2'b00, 4'b0010, 1'b1});
    step(1'b0, 32'd0);
    check("illegal_idle", obs, 15'd0);

    // Randomized stream against the mnemonic model.
    for (int n = 0; n < 400; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      ri = rand_instr();
      step(rv, ri);
      check("random", obs, ref_model(rv, ri));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
